axi4_pattern_master: RTL and testbench
======================================

// Module: axi4_pattern_master
// PURPOSE
//  AXI4 burst master that drives an axi4_ifc slave port (e.g. axi4_sram) from upstream.
//  On start it writes a deterministic data pattern as INCR bursts, reads it all back, and
//  compares each beat. Serves as the traffic source and self-checker for AXI4 memory blocks.
// PARAMETERS
//  AWIDTH    32  address width of axi4_ifc
//  DWIDTH    32  data width of axi4_ifc (8..1024, power of 2)
//  IWIDTH    1   ID width; all IDs driven 0
//  BURSTLEN  16  beats per burst, 1..256; awlen/arlen = BURSTLEN-1
// PORTS
//  clk        in   1       clock; all logic on posedge
//  reset      in   1       synchronous, active-high reset
//  start      in   1       1-cycle pulse: begin run; ignored while busy=1
//  base_addr  in   AWIDTH  byte address of first beat; sampled on start
//  nbursts    in   16      bursts per phase; sampled on start
//  seed       in   DWIDTH  pattern seed; sampled on start
//  busy       out  1       run in progress
//  done       out  1       high from end of run until next accepted start
//  errors     out  16      error count, saturates at 16'hFFFF
//  err_addr   out  AWIDTH  byte address of first failing beat (0 if none)
//  m          --   ifc     axi4_ifc master modport (AW, W, B, AR, R channels)
// BEHAVIOUR
//  Reset: busy=0 done=0 errors=0 err_addr=0; awvalid=wvalid=arvalid=0; bready=rready=0.
//  Constants: awsize/arsize=log2(DWIDTH/8), burst=INCR, lock/cache/prot/qos=0, wstrb all 1s.
//  Beat k (0..nbursts*BURSTLEN-1): addr=base_addr+k*(DWIDTH/8); data=seed+k (DWIDTH wrap).
//  Burst b address = base_addr + b*BURSTLEN*(DWIDTH/8); no 4KB-crossing check (user's job).
//  FSM: IDLE->WADDR->WDATA->WRESP->(next burst WADDR | RADDR)->RDATA->(next RADDR | FIN)->IDLE.
//   IDLE : start accepted -> busy=1, done=0, errors=0, err_addr=0, counters cleared, latch inputs.
//          nbursts=0 -> FIN directly; no valid ever asserted.
//   WADDR: awvalid=1 held with stable awaddr/awlen until awready; then WDATA.
//   WDATA: wvalid=1; beat advances only on wvalid&wready; wlast=1 on beat BURSTLEN-1.
//          Data/last held stable while wready=0. After last beat -> WRESP.
//   WRESP: bready=1; on bvalid: bresp!=OKAY -> error at burst's first beat address.
//   RADDR: arvalid=1 until arready; then RDATA.
//   RDATA: rready=1; per rvalid beat: rdata!=expected, rresp!=OKAY, or rlast!=(beat==BURSTLEN-1)
//          -> one error (max one per beat). rlast on final beat ends burst regardless.
//   FIN  : 1 cycle; busy=0, done=1 next cycle; return to IDLE.
//  AW and W are sequential (no W before AW accepted); one outstanding burst max.
//  Latency: start -> awvalid 1 cycle; FIN -> done 1 cycle.
//  Error: errors+=1 (saturating); err_addr written only if errors was 0.
//  start while busy: ignored, no state change. start same cycle as reset: reset wins.
//  Reset mid-run: all valids/readies drop next cycle; slave must be reset together.
// CONFIGURATION
//  AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN
//   defined  : first error ends run; finish current burst's handshakes (drain W/B or R
//              to rlast), then FIN; errors reads 1.
//   undefined: run always completes all bursts; every error counted.
// TESTING (bench: this block + axi4_sram, or scripted slave where noted)
//  1 BURSTLEN=16, base=0, nbursts=4, seed=0x1000 -> 4 AW, 64 W, 4 B, 4 AR, 64 R; errors=0, done=1.
//  2 nbursts=0, start -> no AXI valid ever, done=1 two cycles after start, busy 1 cycle.
//  3 scripted slave flips bit0 of read beat 5 of burst 2, base=0x100 -> errors=1,
//    err_addr=0x100+(37*4)=0x194; with STOP_ON_ERROR_EN no AR for burst 3.
//  4 random awready/wready/arready/rvalid stalls (50%) on test 1 -> identical result,
//    W/R payload stable during stalls (assertions).
//  5 scripted slave bresp=SLVERR on burst 1, base=0 -> errors>=1, err_addr=0x40.
//  6 reset during WDATA beat 7 -> next cycle all valids 0, busy=0, done=0; new start runs clean.

Source files
------------

// File: rtl/axi4_pattern_master_if.sv
// AXI4 bus bundle used between axi4_pattern_master and an AXI4 memory slave.
// Carries the AW, W, B, AR and R channels. The master and slave modports fix signal direction.
interface axi4_pattern_master_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned IWIDTH = 1
);
  // Write address channel
  logic [IWIDTH-1:0]   awid;
  logic [AWIDTH-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic [IWIDTH-1:0]   bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address channel
  logic [IWIDTH-1:0]   arid;
  logic [AWIDTH-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [IWIDTH-1:0]   rid;
  logic [DWIDTH-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_pattern_master.sv
// AXI4 pattern master: writes seed+k to nbursts INCR bursts starting at base_addr, then reads
// everything back and counts mismatching or badly-responded beats.
// Optional build macro AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN: first error ends the run once the
// current burst's handshakes have drained; only that one error is counted.
module axi4_pattern_master #(
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned IWIDTH   = 1,
  parameter int unsigned BURSTLEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [15:0]       nbursts,
  input  logic [DWIDTH-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       errors,
  output logic [AWIDTH-1:0] err_addr,
  axi4_pattern_master_if.master m
);

  localparam int unsigned Bytes      = DWIDTH / 8;
  localparam int unsigned SizeLog    = $clog2(Bytes);
  localparam logic [8:0]  LastBeat   = 9'(BURSTLEN - 1);
  localparam logic [AWIDTH-1:0] BurstBytes = AWIDTH'(BURSTLEN * Bytes);

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StWresp,
    StRaddr,
    StRdata,
    StFin
  } state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       errors_q;
  logic [AWIDTH-1:0] err_addr_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              wlast_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [AWIDTH-1:0] base_q;
  logic [15:0]       nbursts_q;
  logic [DWIDTH-1:0] seed_q;
  // Expected/driven data for the current beat; doubles as the W payload register.
  logic [DWIDTH-1:0] pattern_q;
  logic [15:0]       burst_cnt_q;
  logic [AWIDTH-1:0] burst_addr_q;
  logic [8:0]        beat_q;

  logic              err_hit;
  logic [AWIDTH-1:0] err_loc;
  logic              count_ok;
  logic              stop_now;
  logic              last_burst;
  logic              rlast_exp;

`ifdef AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN
  logic stop_q;
  // An error seen this cycle stops the run as soon as the burst drains.
  assign stop_now = stop_q | err_hit;
  assign count_ok = (errors_q == 16'd0);
`else
  assign stop_now = 1'b0;
  assign count_ok = (errors_q != 16'hFFFF);
`endif

  assign last_burst = (burst_cnt_q == (nbursts_q - 16'd1));
  assign rlast_exp  = (beat_q == LastBeat);

  // Constant AXI attributes; IDs are always zero.
  assign m.awid    = '0;
  assign m.awaddr  = burst_addr_q;
  assign m.awlen   = 8'(BURSTLEN - 1);
  assign m.awsize  = 3'(SizeLog);
  assign m.awburst = 2'b01;
  assign m.awlock  = 1'b0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.awqos   = 4'd0;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = pattern_q;
  assign m.wstrb   = '1;
  assign m.wlast   = wlast_q;
  assign m.wvalid  = wvalid_q;
  assign m.bready  = bready_q;
  assign m.arid    = '0;
  assign m.araddr  = burst_addr_q;
  assign m.arlen   = 8'(BURSTLEN - 1);
  assign m.arsize  = 3'(SizeLog);
  assign m.arburst = 2'b01;
  assign m.arlock  = 1'b0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arqos   = 4'd0;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign errors   = errors_q;
  assign err_addr = err_addr_q;

  // Response IDs carry no information for a single-ID master.
  logic unused_ids;
  assign unused_ids = ^{m.bid, m.rid};

  // Detect an error on the current B or R handshake and the byte address it belongs to.
  always_comb begin
    err_hit = 1'b0;
    err_loc = burst_addr_q;
    unique case (state_q)
      StWresp: begin
        if (m.bvalid && bready_q && (m.bresp != 2'b00)) err_hit = 1'b1;
      end
      StRdata: begin
        if (m.rvalid && rready_q &&
            ((m.rdata != pattern_q) || (m.rresp != 2'b00) || (m.rlast != rlast_exp))) begin
          err_hit = 1'b1;
          err_loc = burst_addr_q + (AWIDTH'(beat_q) << SizeLog);
        end
      end
      default: ;
    endcase
  end

  // Run sequencing, channel handshakes and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      errors_q     <= 16'd0;
      err_addr_q   <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      base_q       <= '0;
      nbursts_q    <= 16'd0;
      seed_q       <= '0;
      pattern_q    <= '0;
      burst_cnt_q  <= 16'd0;
      burst_addr_q <= '0;
      beat_q       <= 9'd0;
`ifdef AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN
      stop_q       <= 1'b0;
`endif
    end else begin
      if (err_hit && count_ok) begin
        errors_q <= errors_q + 16'd1;
        if (errors_q == 16'd0) err_addr_q <= err_loc;
      end
`ifdef AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN
      if (err_hit) stop_q <= 1'b1;
`endif
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            errors_q     <= 16'd0;
            err_addr_q   <= '0;
            base_q       <= base_addr;
            nbursts_q    <= nbursts;
            seed_q       <= seed;
            pattern_q    <= seed;
            burst_cnt_q  <= 16'd0;
            burst_addr_q <= base_addr;
            beat_q       <= 9'd0;
`ifdef AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN
            stop_q       <= 1'b0;
`endif
            if (nbursts == 16'd0) begin
              state_q <= StFin;
            end else begin
              awvalid_q <= 1'b1;
              state_q   <= StWaddr;
            end
          end
        end
        StWaddr: begin
          if (m.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (LastBeat == 9'd0);
            beat_q    <= 9'd0;
            state_q   <= StWdata;
          end
        end
        StWdata: begin
          if (m.wready) begin
            pattern_q <= pattern_q + DWIDTH'(1);
            beat_q    <= beat_q + 9'd1;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StWresp;
            end else begin
              wlast_q <= ((beat_q + 9'd1) == LastBeat);
            end
          end
        end
        StWresp: begin
          if (m.bvalid) begin
            bready_q <= 1'b0;
            if (stop_now) begin
              state_q <= StFin;
            end else if (last_burst) begin
              // Write phase complete: rewind address and pattern for the read-back.
              burst_cnt_q  <= 16'd0;
              burst_addr_q <= base_q;
              pattern_q    <= seed_q;
              arvalid_q    <= 1'b1;
              state_q      <= StRaddr;
            end else begin
              burst_cnt_q  <= burst_cnt_q + 16'd1;
              burst_addr_q <= burst_addr_q + BurstBytes;
              awvalid_q    <= 1'b1;
              state_q      <= StWaddr;
            end
          end
        end
        StRaddr: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= 9'd0;
            state_q   <= StRdata;
          end
        end
        StRdata: begin
          if (m.rvalid) begin
            pattern_q <= pattern_q + DWIDTH'(1);
            beat_q    <= beat_q + 9'd1;
            // The slave's rlast closes the burst even if it arrives early or late.
            if (m.rlast) begin
              rready_q <= 1'b0;
              if (stop_now || last_burst) begin
                state_q <= StFin;
              end else begin
                burst_cnt_q  <= burst_cnt_q + 16'd1;
                burst_addr_q <= burst_addr_q + BurstBytes;
                arvalid_q    <= 1'b1;
                state_q      <= StRaddr;
              end
            end
          end
        end
        StFin: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_pattern_master.sv
// Directed bench for axi4_pattern_master with a scripted AXI4 memory slave that can stall,
// corrupt one read beat or return SLVERR on one write response.
module tb_axi4_pattern_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] nbursts = '0;
  logic [31:0] seed = '0;
  logic        busy;
  logic        done;
  logic [15:0] errors;
  logic [31:0] err_addr;

  int checks = 0;
  int errs = 0;

  axi4_pattern_master_if #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1)) ifc ();

  axi4_pattern_master #(.AWIDTH(32), .DWIDTH(32), .IWIDTH(1), .BURSTLEN(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .nbursts   (nbursts),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .errors    (errors),
    .err_addr  (err_addr),
    .m         (ifc)
  );

  always #5 clk = ~clk;

  // Slave state; counters only ever increase, the stimulus works with deltas.
  logic [31:0] mem [0:1023];
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_vcyc = 0;
  logic [31:0] s_waddr = '0, s_raddr = '0;
  bit          r_act = 0;
  int          rbeat = 0;
  int          r_idx = 0;
  bit          stall_en = 0;
  int          flip_idx = -1;
  int          bad_b_idx = -1;

  assign ifc.bid = '0;
  assign ifc.rid = '0;

  // Scripted memory slave.
  always @(posedge clk) begin : slave
    int         nb;
    bit         cons;
    logic [9:0] idx;
    logic [31:0] d;
    if (reset) begin
      ifc.awready <= 1'b0;
      ifc.wready  <= 1'b0;
      ifc.arready <= 1'b0;
      ifc.bvalid  <= 1'b0;
      ifc.bresp   <= 2'b00;
      ifc.rvalid  <= 1'b0;
      ifc.rlast   <= 1'b0;
      ifc.rdata   <= '0;
      ifc.rresp   <= 2'b00;
      r_act       <= 0;
      rbeat       <= 0;
    end else begin
      if (ifc.awvalid || ifc.wvalid || ifc.arvalid) n_vcyc <= n_vcyc + 1;
      ifc.awready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.wready  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.arready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ifc.awvalid && ifc.awready) begin
        s_waddr <= ifc.awaddr;
        n_aw    <= n_aw + 1;
      end
      if (ifc.wvalid && ifc.wready) begin
        mem[s_waddr[11:2]] <= ifc.wdata;
        s_waddr <= s_waddr + 32'd4;
        n_w     <= n_w + 1;
        if (ifc.wlast) begin
          ifc.bvalid <= 1'b1;
          ifc.bresp  <= (n_b == bad_b_idx) ? 2'b10 : 2'b00;
        end
      end
      if (ifc.bvalid && ifc.bready) begin
        ifc.bvalid <= 1'b0;
        n_b        <= n_b + 1;
      end
      if (ifc.arvalid && ifc.arready) begin
        s_raddr <= ifc.araddr;
        r_act   <= 1;
        rbeat   <= 0;
        r_idx   <= n_ar;
        n_ar    <= n_ar + 1;
      end
      cons = ifc.rvalid && ifc.rready;
      if (cons) n_r <= n_r + 1;
      nb = cons ? rbeat + 1 : rbeat;
      if (cons && ifc.rlast) begin
        ifc.rvalid <= 1'b0;
        ifc.rlast  <= 1'b0;
        r_act      <= 0;
      end else if (r_act && (!ifc.rvalid || cons)) begin
        if (!stall_en || $urandom_range(0, 1) == 1) begin
          idx = s_raddr[11:2] + 10'(nb);
          d   = mem[idx];
          if (r_idx == flip_idx && nb == 5) d[0] = ~d[0];
          ifc.rdata  <= d;
          ifc.rvalid <= 1'b1;
          ifc.rlast  <= (nb == 15);
          ifc.rresp  <= 2'b00;
        end else begin
          ifc.rvalid <= 1'b0;
        end
        rbeat <= nb;
      end
    end
  end

  // Payload of a stalled AW/W/AR transfer must not move until accepted.
  bit          p_wstall = 0, p_awstall = 0, p_arstall = 0;
  logic [31:0] p_wdata = '0, p_awaddr = '0, p_araddr = '0;
  logic        p_wlast = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      p_wstall  <= 0;
      p_awstall <= 0;
      p_arstall <= 0;
    end else begin
      if (p_wstall) begin
        checks++;
        assert (ifc.wvalid === 1'b1 && ifc.wdata === p_wdata && ifc.wlast === p_wlast)
        else begin
          errs++;
          $error("FAIL w_stable obs=%0b/%h/%0b exp=1/%h/%0b", ifc.wvalid, ifc.wdata, ifc.wlast,
                 p_wdata, p_wlast);
        end
      end
      if (p_awstall) begin
        checks++;
        assert (ifc.awvalid === 1'b1 && ifc.awaddr === p_awaddr)
        else begin
          errs++;
          $error("FAIL aw_stable obs=%0b/%h exp=1/%h", ifc.awvalid, ifc.awaddr, p_awaddr);
        end
      end
      if (p_arstall) begin
        checks++;
        assert (ifc.arvalid === 1'b1 && ifc.araddr === p_araddr)
        else begin
          errs++;
          $error("FAIL ar_stable obs=%0b/%h exp=1/%h", ifc.arvalid, ifc.araddr, p_araddr);
        end
      end
      p_wstall  <= ifc.wvalid && !ifc.wready;
      p_wdata   <= ifc.wdata;
      p_wlast   <= ifc.wlast;
      p_awstall <= ifc.awvalid && !ifc.awready;
      p_awaddr  <= ifc.awaddr;
      p_arstall <= ifc.arvalid && !ifc.arready;
      p_araddr  <= ifc.araddr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    bit got;
    base_addr = b;
    nbursts   = n;
    seed      = s;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got = 0;
    for (int i = 0; i < 6000; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("run_done", 64'(got), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
  endtask

  int s_aw, s_w, s_b, s_ar, s_r, s_v;

  task automatic snap();
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r; s_v = n_vcyc;
  endtask

  initial begin
    bit found;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_errors", 64'(errors), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_valids", 64'({ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready}),
        64'd0);
    reset = 1'b0;

    // 1: clean run, 4 bursts of 16 beats
    snap();
    run(32'h0, 16'd4, 32'h1000);
    chk("t1_errors", 64'(errors), 64'd0);
    chk("t1_aw", 64'(n_aw - s_aw), 64'd4);
    chk("t1_w", 64'(n_w - s_w), 64'd64);
    chk("t1_b", 64'(n_b - s_b), 64'd4);
    chk("t1_ar", 64'(n_ar - s_ar), 64'd4);
    chk("t1_r", 64'(n_r - s_r), 64'd64);
    chk("t1_mem0", 64'(mem[0]), 64'h1000);
    chk("t1_mem63", 64'(mem[63]), 64'h103F);

    // 2: nbursts=0 finishes without bus activity
    snap();
    nbursts = 16'd0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("t2_busy1", 64'({busy, done}), 64'b10);
    @(posedge clk); #1;
    chk("t2_done", 64'({busy, done}), 64'b01);
    chk("t2_novalid", 64'(n_vcyc - s_v), 64'd0);

    // 3: bit flip in read beat 5 of burst 2
    snap();
    flip_idx = n_ar + 2;
    run(32'h100, 16'd4, 32'hA5A5_0000);
    flip_idx = -1;
    chk("t3_errors", 64'(errors), 64'd1);
    chk("t3_err_addr", 64'(err_addr), 64'h194);
`ifdef AXI4_PATTERN_MASTER_STOP_ON_ERROR_EN
    chk("t3_ar", 64'(n_ar - s_ar), 64'd3);
`else
    chk("t3_ar", 64'(n_ar - s_ar), 64'd4);
`endif

    // 4: random stalls on every channel
    snap();
    stall_en = 1;
    run(32'h0, 16'd4, 32'h2000);
    stall_en = 0;
    chk("t4_errors", 64'(errors), 64'd0);
    chk("t4_w", 64'(n_w - s_w), 64'd64);
    chk("t4_r", 64'(n_r - s_r), 64'd64);
    chk("t4_mem17", 64'(mem[17]), 64'h2011);

    // 5: SLVERR on write burst 1
    snap();
    bad_b_idx = n_b + 1;
    run(32'h0, 16'd4, 32'h3000);
    bad_b_idx = -1;
    chk("t5_errors", 64'(errors), 64'd1);
    chk("t5_err_addr", 64'(err_addr), 64'h40);

    // 6: reset while W beat 7 is on the bus
    snap();
    base_addr = 32'h0;
    nbursts   = 16'd4;
    seed      = 32'h4000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (n_w - s_w == 7) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t6_reach_beat7", 64'(found), 64'd1);
    chk("t6_wvalid_pre", 64'(ifc.wvalid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_valids", 64'({ifc.awvalid, ifc.wvalid, ifc.arvalid}), 64'd0);
    chk("t6_busy_done", 64'({busy, done}), 64'd0);
    reset = 1'b0;
    run(32'h80, 16'd2, 32'h55);
    chk("t6_errors", 64'(errors), 64'd0);
    chk("t6_mem", 64'(mem[32]), 64'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
